tone_sequencer: RTL and testbench
=================================

// Module: tone_sequencer
// PURPOSE
//  Parametrised sound-effect sequencer for the MSS audio path. Each game event
//  (bottom hit, brick hit, bat hit, ...) launches a short melody of up to
//  NOTES_PER_EVENT notes, with a programmable note duration and event priority.
//  It drives the per-note prescaler value to the tone generator, plus a gate
//  signal for sound on/off.
// PARAMETERS
//  NUM_EVENTS       3                  number of event inputs; index 0 = highest priority
//  NOTES_PER_EVENT  4                  melody slots per event
//  NOTE_TICKS       4                  tick_en pulses per note (1..255)
//  OCTAVE_SHIFT     0                  prescale >> OCTAVE_SHIFT (0..3); each step is +1 octave
//  PRESCALE_W       10                 output width (>=10; table values are zero-extended)
//  MELODY           48'hF8C8_FFF5_F047 NUM_EVENTS*NOTES_PER_EVENT nibbles; note k of
//                                      event e at [(e*NOTES_PER_EVENT+k)*4 +: 4]
// PORTS
//  clk           in   1             system clock
//  reset         in   1             synchronous, active-high reset
//  tick_en       in   1             duration strobe (e.g. 1 ms), one clk wide
//  event_pulse   in   NUM_EVENTS    event requests; level sampled every clk
//  preScaleValue out  PRESCALE_W    prescaler for the tone generator
//  sound_on      out  1             1 = a note is sounding
//  busy          out  1             1 = a melody is in progress
//  cur_event     out  $clog2(NUM_EVENTS)  index of the playing event
// BEHAVIOUR
//  Reset: all outputs are 0; state IDLE; note index and tick counter are 0.
//  Note codes:
//   0..11 = do,doD,re,reD,mi,fa,faD,sol,solD,la,laD,si
//           -> 2EA,2C0,299,273,250,22F,20F,1F2,1D6,1BB,345,316 (hex).
//   12..14 = rest: sound_on=0, preScaleValue holds its last value.
//   15 = end: the melody terminates immediately.
//  States:
//   IDLE: waits for any event_pulse bit. The lowest set index wins.
//   PLAY: holds cur_event, note index k and tick counter t.
//  Start: the event is sampled at edge N. From edge N+1, busy=1, cur_event=e,
//   k=0, t=0, and the outputs reflect note 0. All outputs are registered, so
//   latency is 1 clk.
//  Note advance (PLAY): each tick_en increments t. When t would reach NOTE_TICKS,
//   t goes to 0 and k goes to k+1.
//  Finish: after the final slot expires, or when the next slot holds code 15,
//   the block enters IDLE on that same edge. In IDLE: busy=0, sound_on=0, and
//   preScaleValue holds its value.
//  Code 15 in slot 0: the event is accepted but plays nothing. busy pulses
//   high for 1 clk and sound_on stays 0.
//  Preemption in PLAY:
//   - A new event with index <= cur_event restarts the melody at that event
//     (k=0, t=0), which permits retriggering the same event.
//   - A new event with index > cur_event is ignored and dropped, not queued.
//   - Event and tick_en on the same edge: the event wins; that tick is discarded.
//  Output arithmetic: preScaleValue = {zero-ext(table[code])} >> OCTAVE_SHIFT.
//   Truncation is permitted only for PRESCALE_W >= 10 (no truncation occurs).
//  Counters:
//   - t has width $clog2(NOTE_TICKS+1) and never wraps past NOTE_TICKS-1.
//   - k never exceeds NOTES_PER_EVENT-1.
//  tick_en in IDLE: ignored.
//  Reset asserted mid-melody: on the next edge the block returns to its reset
//   values, regardless of event_pulse.
// TESTING
//  1. reset 3 clk, then event_pulse=3'b010 for 1 clk -> next clk: busy=1,
//     cur_event=1, preScaleValue=22F, sound_on=1. After 4 ticks, slot 1=F
//     -> IDLE, busy=0, sound_on=0, preScaleValue stays 22F.
//  2. event0 with NOTE_TICKS=4 -> sequence 1F2, 250, 2EA at 4 ticks each,
//     then idle. Check exactly 12 tick_en pulses to finish.
//  3. event2 playing at slot 1 (rest code C) -> sound_on=0 while
//     preScaleValue=1D6; slot 2 -> sound_on=1, 1D6.
//  4. Preemption:
//     - event2 playing, then event_pulse=3'b001 -> next clk cur_event=0,
//       preScaleValue=1F2, k=0.
//     - event0 playing, then event_pulse=3'b100 -> ignored, melody unchanged.
//  5. event_pulse=3'b111 in IDLE -> cur_event=0. Event0 retrigger on the same
//     edge as tick_en -> t=0, k=0, and the tick is lost.
//  6. OCTAVE_SHIFT=1, event1 -> preScaleValue=117. Reset asserted at k=1
//     of event0 -> next clk all outputs 0, state IDLE.

Source files
------------

// File: rtl/tone_sequencer_if.sv
// Purpose : bundles the event/tick inputs and the tone outputs of tone_sequencer.
// Signals : tick_en       - duration strobe, one clk wide
//           event_pulse   - event requests, bit 0 = highest priority
//           preScaleValue - prescaler value for the tone generator
//           sound_on      - a note is sounding
//           busy          - a melody is in progress
//           cur_event     - index of the playing event
// Modports: master = event source / tone consumer, slave = the sequencer.
interface tone_sequencer_if #(
    parameter int unsigned NUM_EVENTS = 3,
    parameter int unsigned PRESCALE_W = 10
);
    localparam int unsigned EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    logic                  tick_en;
    logic [NUM_EVENTS-1:0] event_pulse;
    logic [PRESCALE_W-1:0] preScaleValue;
    logic                  sound_on;
    logic                  busy;
    logic [EW-1:0]         cur_event;

    modport master (
        output tick_en, event_pulse,
        input  preScaleValue, sound_on, busy, cur_event
    );

    modport slave (
        input  tick_en, event_pulse,
        output preScaleValue, sound_on, busy, cur_event
    );
endinterface

// File: rtl/tone_sequencer.sv
// Purpose : sound-effect sequencer. Each event input launches a short melody of
//           up to NOTES_PER_EVENT notes, each lasting NOTE_TICKS tick_en pulses.
//           Lower event index has priority and may preempt a playing melody.
// Ports   : clk   - system clock
//           reset - synchronous, active-high reset
//           bus   - tone_sequencer_if slave (tick_en, event_pulse in;
//                   preScaleValue, sound_on, busy, cur_event out)
// All outputs are registered (1 clk latency from event/tick to output).
module tone_sequencer #(
    parameter int unsigned NUM_EVENTS      = 3,
    parameter int unsigned NOTES_PER_EVENT = 4,
    parameter int unsigned NOTE_TICKS      = 4,
    parameter int unsigned OCTAVE_SHIFT    = 0,
    parameter int unsigned PRESCALE_W      = 10,
    parameter logic [NUM_EVENTS*NOTES_PER_EVENT*4-1:0] MELODY = 48'hF8C8_FFF5_F047
) (
    input logic             clk,
    input logic             reset,
    tone_sequencer_if.slave bus
);
    localparam int unsigned   EW       = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;
    localparam int unsigned   KW       = (NOTES_PER_EVENT > 1) ? $clog2(NOTES_PER_EVENT) : 1;
    localparam int unsigned   TW       = $clog2(NOTE_TICKS + 1);
    localparam logic [KW-1:0] K_LAST   = KW'(NOTES_PER_EVENT - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(NOTE_TICKS - 1);
    localparam logic [3:0]    CODE_END = 4'hF;

    typedef enum logic {IDLE, PLAY} state_t;

    state_t                state_q, state_d;
    logic [EW-1:0]         cur_q, cur_d;
    logic [KW-1:0]         k_q, k_d;
    logic [TW-1:0]         t_q, t_d;
    logic                  busy_q, busy_d;
    logic                  snd_q, snd_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;

    logic                  ev_any;
    logic [EW-1:0]         ev_sel;
    logic [3:0]            code_start, code_cur, code_next, load_code;
    logic                  load;

    function automatic logic [9:0] note_period(input logic [3:0] code);
        case (code)
            4'd0:    return 10'h2EA;
            4'd1:    return 10'h2C0;
            4'd2:    return 10'h299;
            4'd3:    return 10'h273;
            4'd4:    return 10'h250;
            4'd5:    return 10'h22F;
            4'd6:    return 10'h20F;
            4'd7:    return 10'h1F2;
            4'd8:    return 10'h1D6;
            4'd9:    return 10'h1BB;
            4'd10:   return 10'h345;
            4'd11:   return 10'h316;
            default: return 10'h000;
        endcase
    endfunction

    function automatic logic [3:0] slot_code(input logic [EW-1:0] e, input logic [KW-1:0] k);
        int unsigned base;
        base = (32'(e) * NOTES_PER_EVENT + 32'(k)) * 4;
        return MELODY[base +: 4];
    endfunction

    // Lowest set request index wins.
    always_comb begin
        ev_any = 1'b0;
        ev_sel = '0;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            if (bus.event_pulse[i] && !ev_any) begin
                ev_any = 1'b1;
                ev_sel = EW'(i);
            end
        end
    end

    // Past the last slot reads as an end code so the melody stops there.
    always_comb begin
        code_start = slot_code(ev_sel, '0);
        code_cur   = slot_code(cur_q, k_q);
        code_next  = (k_q == K_LAST) ? CODE_END : slot_code(cur_q, k_q + 1'b1);
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        k_d       = k_q;
        t_d       = t_q;
        busy_d    = busy_q;
        snd_d     = snd_q;
        pre_d     = pre_q;
        load      = 1'b0;
        load_code = code_start;

        unique case (state_q)
            IDLE: begin
                if (ev_any) begin
                    state_d = PLAY;
                    cur_d   = ev_sel;
                    k_d     = '0;
                    t_d     = '0;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            PLAY: begin
                // A start/restart takes precedence over a same-edge tick,
                // which is then simply discarded.
                if (ev_any && (ev_sel <= cur_q)) begin
                    cur_d  = ev_sel;
                    k_d    = '0;
                    t_d    = '0;
                    busy_d = 1'b1;
                    load   = 1'b1;
                end else if (code_cur == CODE_END) begin
                    state_d = IDLE;
                    k_d     = '0;
                    t_d     = '0;
                    busy_d  = 1'b0;
                    snd_d   = 1'b0;
                end else if (bus.tick_en) begin
                    if (t_q == T_LAST) begin
                        if (code_next == CODE_END) begin
                            state_d = IDLE;
                            k_d     = '0;
                            t_d     = '0;
                            busy_d  = 1'b0;
                            snd_d   = 1'b0;
                        end else begin
                            k_d       = k_q + 1'b1;
                            t_d       = '0;
                            load      = 1'b1;
                            load_code = code_next;
                        end
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
        endcase

        // Rests (and an end code in slot 0) mute but keep the last prescaler.
        if (load) begin
            if (load_code < 4'd12) begin
                pre_d = PRESCALE_W'(note_period(load_code)) >> OCTAVE_SHIFT;
                snd_d = 1'b1;
            end else begin
                snd_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            k_q     <= '0;
            t_q     <= '0;
            busy_q  <= 1'b0;
            snd_q   <= 1'b0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            k_q     <= k_d;
            t_q     <= t_d;
            busy_q  <= busy_d;
            snd_q   <= snd_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.preScaleValue = pre_q;
    assign bus.sound_on      = snd_q;
    assign bus.busy          = busy_q;
    assign bus.cur_event     = cur_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: expected outputs are queued when each stimulus
// cycle is driven and compared 1 ns after the following clock edge.
// A second instance with OCTAVE_SHIFT=1 sees the same inputs.
module tb_tone_sequencer;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tone_sequencer_if #(.NUM_EVENTS(3), .PRESCALE_W(10)) bus ();
    tone_sequencer_if #(.NUM_EVENTS(3), .PRESCALE_W(10)) bus_oct ();

    assign bus_oct.tick_en     = bus.tick_en;
    assign bus_oct.event_pulse = bus.event_pulse;

    tone_sequencer #(
        .NUM_EVENTS(3), .NOTES_PER_EVENT(4), .NOTE_TICKS(4),
        .OCTAVE_SHIFT(0), .PRESCALE_W(10), .MELODY(48'hF8C8_FFF5_F047)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    tone_sequencer #(
        .NUM_EVENTS(3), .NOTES_PER_EVENT(4), .NOTE_TICKS(4),
        .OCTAVE_SHIFT(1), .PRESCALE_W(10), .MELODY(48'hF8C8_FFF5_F047)
    ) u_dut_oct (
        .clk(clk), .reset(reset), .bus(bus_oct)
    );

    typedef struct {
        string      tag;
        logic       busy;
        logic       snd;
        logic [9:0] pre;
        int         cur;   // -1: cur_event not checked
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, ".busy"}, 32'(bus.busy), 32'(mon_e.busy));
            chk({mon_e.tag, ".sound_on"}, 32'(bus.sound_on), 32'(mon_e.snd));
            chk({mon_e.tag, ".pre"}, 32'(bus.preScaleValue), 32'(mon_e.pre));
            if (mon_e.cur >= 0)
                chk({mon_e.tag, ".cur"}, 32'(bus.cur_event), 32'(mon_e.cur));
            chk({mon_e.tag, ".oct_pre"}, 32'(bus_oct.preScaleValue), 32'(10'(mon_e.pre >> 1)));
            chk({mon_e.tag, ".oct_busy"}, 32'(bus_oct.busy), 32'(mon_e.busy));
        end
    end

    task automatic step(input logic [2:0] ev, input logic tk, input logic rs, input string tag,
                        input logic b, input logic s, input logic [9:0] p, input int c);
        exp_t e;
        @(negedge clk);
        bus.event_pulse = ev;
        bus.tick_en     = tk;
        reset           = rs;
        e.tag  = tag;
        e.busy = b;
        e.snd  = s;
        e.pre  = p;
        e.cur  = c;
        sb.push_back(e);
    endtask

    initial begin
        reset           = 1'b1;
        bus.event_pulse = '0;
        bus.tick_en     = 1'b0;

        for (int i = 0; i < 3; i++)
            step(3'b000, 1'b0, 1'b1, "reset", 1'b0, 1'b0, 10'h000, 0);
        step(3'b000, 1'b1, 1'b0, "idle_tick", 1'b0, 1'b0, 10'h000, 0);

        // Event 1: fa, then end code in slot 1.
        step(3'b010, 1'b0, 1'b0, "t1_start", 1'b1, 1'b1, 10'h22F, 1);
        for (int i = 1; i <= 3; i++)
            step(3'b000, 1'b1, 1'b0, "t1_tick", 1'b1, 1'b1, 10'h22F, 1);
        step(3'b000, 1'b1, 1'b0, "t1_end", 1'b0, 1'b0, 10'h22F, -1);
        step(3'b000, 1'b1, 1'b0, "t1_idle", 1'b0, 1'b0, 10'h22F, -1);

        // Event 0: sol, mi, do at 4 ticks each; idle cycles in between.
        step(3'b001, 1'b0, 1'b0, "t2_start", 1'b1, 1'b1, 10'h1F2, 0);
        for (int i = 1; i <= 12; i++) begin
            logic [9:0] p;
            p = (i < 4) ? 10'h1F2 : (i < 8) ? 10'h250 : 10'h2EA;
            if (i < 12) begin
                step(3'b000, 1'b1, 1'b0, "t2_tick", 1'b1, 1'b1, p, 0);
                step(3'b000, 1'b0, 1'b0, "t2_gap", 1'b1, 1'b1, p, 0);
            end else begin
                step(3'b000, 1'b1, 1'b0, "t2_end", 1'b0, 1'b0, p, -1);
                step(3'b000, 1'b0, 1'b0, "t2_idle", 1'b0, 1'b0, p, -1);
            end
        end

        // Event 2: solD, rest, solD.
        step(3'b100, 1'b0, 1'b0, "t3_start", 1'b1, 1'b1, 10'h1D6, 2);
        for (int i = 1; i <= 8; i++)
            step(3'b000, 1'b1, 1'b0, (i >= 4 && i < 8) ? "t3_rest" : "t3_note",
                 1'b1, !(i >= 4 && i < 8), 10'h1D6, 2);

        // Higher priority preempts; lower priority is dropped, tick still counts.
        step(3'b001, 1'b0, 1'b0, "t4_preempt", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b100, 1'b0, 1'b0, "t4_ignore", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b000, 1'b1, 1'b0, "t4_tick1", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b000, 1'b1, 1'b0, "t4_tick2", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b100, 1'b1, 1'b0, "t4_ign_tick", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b000, 1'b1, 1'b0, "t4_adv", 1'b1, 1'b1, 10'h250, 0);

        // Retrigger with a same-edge tick: the tick is lost.
        for (int i = 1; i <= 3; i++)
            step(3'b000, 1'b1, 1'b0, "t5_tick", 1'b1, 1'b1, 10'h250, 0);
        step(3'b001, 1'b1, 1'b0, "t5_retrig", 1'b1, 1'b1, 10'h1F2, 0);
        for (int i = 1; i <= 3; i++)
            step(3'b000, 1'b1, 1'b0, "t5_hold", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b000, 1'b1, 1'b0, "t5_adv", 1'b1, 1'b1, 10'h250, 0);

        // Reset mid-melody (event 0, k=1), with a request present.
        step(3'b001, 1'b0, 1'b1, "t6_reset", 1'b0, 1'b0, 10'h000, 0);
        step(3'b000, 1'b0, 1'b1, "t6_reset2", 1'b0, 1'b0, 10'h000, 0);

        // All requests at once from idle: index 0 wins; index 1 later is dropped.
        step(3'b111, 1'b0, 1'b0, "t5_all", 1'b1, 1'b1, 10'h1F2, 0);
        step(3'b010, 1'b0, 1'b0, "t5_drop", 1'b1, 1'b1, 10'h1F2, 0);

        // Event 1 after reset: octave instance shows 0x117.
        step(3'b000, 1'b0, 1'b1, "t6_rst3", 1'b0, 1'b0, 10'h000, 0);
        step(3'b010, 1'b0, 1'b0, "t6_oct", 1'b1, 1'b1, 10'h22F, 1);

        @(negedge clk);
        bus.event_pulse = '0;
        bus.tick_en     = 1'b0;
        @(negedge clk);
        if (sb.size() != 0)
            chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
